// File: rtl/ysyx_pfl_if.sv
// Rename/commit handshake bundle for the physical-register free list.
// The master side is rename plus commit; the slave side is the free list itself.
interface ysyx_pfl_if #(
  parameter int PLEN = 6
);
  logic            alloc_valid;
  logic            alloc_ready;
  logic [PLEN-1:0] alloc_prd;
  logic            free_valid;
  logic [PLEN-1:0] free_prs;
  logic            commit_alloc;
  logic            flush;
  logic [PLEN:0]   free_count;

  modport master (
    output alloc_valid, free_valid, free_prs, commit_alloc, flush,
    input  alloc_ready, alloc_prd, free_count
  );

  modport slave (
    input  alloc_valid, free_valid, free_prs, commit_alloc, flush,
    output alloc_ready, alloc_prd, free_count
  );
endinterface

// File: rtl/ysyx_pfl.sv
// Physical-register free list: a circular FIFO of free preg indices.
// It has a speculative head for rename, a committed head for flush rollback, and a tail for commit returns.
module ysyx_pfl_chk #(
  parameter int FNUM  = 32,
  parameter int PTR_W = 6
) (
  input logic             i_clock,
  input logic             i_reset,
  input logic [PTR_W-1:0] i_head,
  input logic [PTR_W-1:0] i_chead,
  input logic [PTR_W-1:0] i_tail
);
  localparam logic [PTR_W-1:0] FNUM_P = PTR_W'(FNUM);
  logic [PTR_W-1:0] w_live;
  logic [PTR_W-1:0] w_spec;

  assign w_live = i_tail - i_chead;
  assign w_spec = i_head - i_chead;

  a_no_overfill: assert property (@(posedge i_clock) disable iff (i_reset) w_live <= FNUM_P);
  a_chead_behind_head: assert property (@(posedge i_clock) disable iff (i_reset) w_spec <= w_live);
endmodule

module ysyx_pfl #(
  parameter int PNUM = 64,
  parameter int PLEN = 6,
  parameter int RNUM = 32
) (
  input logic        i_clock,
  input logic        i_reset,
  ysyx_pfl_if.slave  bus
);
  localparam int FNUM  = PNUM - RNUM;
  localparam int FLEN  = $clog2(FNUM);
  localparam int PTR_W = FLEN + 1;
  localparam int CW    = PLEN + 1;
  localparam logic [PTR_W-1:0] ONE_P = {{FLEN{1'b0}}, 1'b1};

  logic [PLEN-1:0]  r_mem [FNUM];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_chead;
  logic [PTR_W-1:0] r_tail;

  logic             w_ready;
  logic             w_alloc_fire;
  logic             w_free_fire;
  logic [PTR_W-1:0] w_chead_next;
  logic [PTR_W-1:0] w_head_next;
  logic [PTR_W-1:0] w_tail_next;
  logic [PTR_W-1:0] w_count;

  // Full and empty differ only in the wrap bit, so the pointers are compared whole.
  assign w_ready = (r_tail != r_head);
  assign w_count = r_tail - r_head;

  assign bus.alloc_ready = w_ready;
  assign bus.alloc_prd   = r_mem[r_head[FLEN-1:0]];
  assign bus.free_count  = CW'(w_count);

  // Next-pointer logic; a flush rolls back to the committed head, including a same-cycle commit.
  always_comb begin
    w_alloc_fire = bus.alloc_valid & w_ready & ~bus.flush;
    w_free_fire  = bus.free_valid & (bus.free_prs != {PLEN{1'b0}});
    w_chead_next = r_chead;
    w_head_next  = r_head;
    w_tail_next  = r_tail;
    if (bus.commit_alloc) begin
      w_chead_next = r_chead + ONE_P;
    end else begin
      w_chead_next = r_chead;
    end
    if (bus.flush) begin
      w_head_next = w_chead_next;
    end else if (w_alloc_fire) begin
      w_head_next = r_head + ONE_P;
    end else begin
      w_head_next = r_head;
    end
    if (w_free_fire) begin
      w_tail_next = r_tail + ONE_P;
    end else begin
      w_tail_next = r_tail;
    end
  end

  // State registers; reset reloads the list with pregs RNUM..PNUM-1.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < FNUM; i++) begin
        r_mem[i] <= PLEN'(RNUM + i);
      end
      r_head  <= {PTR_W{1'b0}};
      r_chead <= {PTR_W{1'b0}};
      r_tail  <= PTR_W'(FNUM);
    end else begin
      if (w_free_fire) begin
        r_mem[r_tail[FLEN-1:0]] <= bus.free_prs;
      end
      r_head  <= w_head_next;
      r_chead <= w_chead_next;
      r_tail  <= w_tail_next;
    end
  end

  ysyx_pfl_chk #(.FNUM(FNUM), .PTR_W(PTR_W)) u_chk (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_head  (r_head),
    .i_chead (r_chead),
    .i_tail  (r_tail)
  );
endmodule

// File: tb/tb_ysyx_pfl.sv
// Self-checking bench for ysyx_pfl: directed scenarios plus a randomized run against a queue-based model.
module tb_ysyx_pfl;
  localparam int PNUM = 64;
  localparam int PLEN = 6;
  localparam int RNUM = 32;
  localparam int FNUM = PNUM - RNUM;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  // Model: q_free holds pregs from committed head to tail; k of them are speculatively taken.
  logic [PLEN-1:0] q_free[$];
  logic [PLEN-1:0] owned[$];
  int              k;
  int              commits;

  ysyx_pfl_if #(.PLEN(PLEN)) bus ();

  ysyx_pfl #(.PNUM(PNUM), .PLEN(PLEN), .RNUM(RNUM)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic av, input logic fv, input logic [PLEN-1:0] fp,
                       input logic ca, input logic fl);
    bus.alloc_valid  = av;
    bus.free_valid   = fv;
    bus.free_prs     = fp;
    bus.commit_alloc = ca;
    bus.flush        = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.alloc_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %0b want 1", bus.alloc_ready);
    end
    checks++;
    if (bus.alloc_prd !== 6'd32) begin
      errors++; $display("FAIL reset_prd: got %0d want 32", bus.alloc_prd);
    end
    checks++;
    if (bus.free_count !== 7'd32) begin
      errors++; $display("FAIL reset_count: got %0d want 32", bus.free_count);
    end
  endtask

  task automatic test_drain();
    do_reset();
    for (int i = 0; i < FNUM; i++) begin
      drive(1'b1, 1'b0, 6'd0, 1'b1, 1'b0);
      checks++;
      if (bus.alloc_prd !== 6'(RNUM + i)) begin
        errors++; $display("FAIL drain_prd[%0d]: got %0d want %0d", i, bus.alloc_prd, RNUM + i);
      end
      tick();
    end
    drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    checks++;
    if (bus.alloc_ready !== 1'b0) begin
      errors++; $display("FAIL drain_ready: got %0b want 0", bus.alloc_ready);
    end
    checks++;
    if (bus.free_count !== 7'd0) begin
      errors++; $display("FAIL drain_count: got %0d want 0", bus.free_count);
    end
  endtask

  task automatic test_empty_free();
    drive(1'b1, 1'b1, 6'd40, 1'b0, 1'b0);
    checks++;
    if (bus.alloc_ready !== 1'b0) begin
      errors++; $display("FAIL empty_nobypass: got ready %0b want 0", bus.alloc_ready);
    end
    tick();
    drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    checks++;
    if (bus.alloc_ready !== 1'b1 || bus.alloc_prd !== 6'd40 || bus.free_count !== 7'd1) begin
      errors++;
      $display("FAIL empty_refill: got ready %0b prd %0d count %0d want 1 40 1",
               bus.alloc_ready, bus.alloc_prd, bus.free_count);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 6'd0, 1'b0, 1'b0); tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 6'd0, 1'b1, 1'b0); tick();
    end
    drive(1'b1, 1'b0, 6'd0, 1'b0, 1'b1); tick();
    drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    checks++;
    if (bus.alloc_prd !== 6'd34 || bus.free_count !== 7'd30) begin
      errors++; $display("FAIL flush_rollback: got prd %0d count %0d want 34 30",
                         bus.alloc_prd, bus.free_count);
    end
  endtask

  task automatic test_flush_commit();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 6'd0, 1'b0, 1'b0); tick();
    end
    drive(1'b0, 1'b0, 6'd0, 1'b1, 1'b0); tick();
    drive(1'b0, 1'b0, 6'd0, 1'b1, 1'b1); tick();
    drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    checks++;
    if (bus.alloc_prd !== 6'd34 || bus.free_count !== 7'd30) begin
      errors++; $display("FAIL flush_commit: got prd %0d count %0d want 34 30",
                         bus.alloc_prd, bus.free_count);
    end
  endtask

  task automatic test_free_zero();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 6'd0, 1'b1, 1'b0); tick();
    end
    drive(1'b0, 1'b1, 6'd0, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    checks++;
    if (bus.free_count !== 7'd29 || bus.alloc_prd !== 6'd35) begin
      errors++; $display("FAIL free_zero: got count %0d prd %0d want 29 35",
                         bus.free_count, bus.alloc_prd);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b1, 1'b0, 6'd0, 1'b1, 1'b0); tick();
    drive(1'b1, 1'b1, 6'd32, 1'b1, 1'b0); tick();
    drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    checks++;
    if (bus.free_count !== 7'd31 || bus.alloc_prd !== 6'd34) begin
      errors++; $display("FAIL b2b_full_minus_one: got count %0d prd %0d want 31 34",
                         bus.free_count, bus.alloc_prd);
    end
    for (int i = 0; i < 30; i++) begin
      drive(1'b1, 1'b0, 6'd0, 1'b1, 1'b0); tick();
    end
    drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    checks++;
    if (bus.alloc_prd !== 6'd32 || bus.free_count !== 7'd1) begin
      errors++; $display("FAIL b2b_wrap: got prd %0d count %0d want 32 1",
                         bus.alloc_prd, bus.free_count);
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 1'b1, 6'd9, 1'b1, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    checks++;
    if (bus.alloc_ready !== 1'b1 || bus.alloc_prd !== 6'd32 || bus.free_count !== 7'd32) begin
      errors++; $display("FAIL mid_reset: got ready %0b prd %0d count %0d want 1 32 32",
                         bus.alloc_ready, bus.alloc_prd, bus.free_count);
    end
  endtask

  task automatic test_random();
    logic            av, fv, ca, fl, fire;
    logic [PLEN-1:0] fp;
    int              idx;
    do_reset();
    q_free.delete();
    owned.delete();
    for (int i = 0; i < FNUM; i++) q_free.push_back(6'(RNUM + i));
    for (int i = 1; i < RNUM; i++) owned.push_back(6'(i));
    k = 0;
    commits = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      checks++;
      if (bus.alloc_ready !== (q_free.size() > k)) begin
        errors++; $display("FAIL rnd_ready@%0d: got %0b want %0b", cyc, bus.alloc_ready, q_free.size() > k);
      end
      checks++;
      if (bus.free_count !== 7'(q_free.size() - k)) begin
        errors++; $display("FAIL rnd_count@%0d: got %0d want %0d", cyc, bus.free_count, q_free.size() - k);
      end
      if (q_free.size() > k) begin
        checks++;
        if (bus.alloc_prd !== q_free[k]) begin
          errors++; $display("FAIL rnd_prd@%0d: got %0d want %0d", cyc, bus.alloc_prd, q_free[k]);
        end
      end
      av = ($urandom_range(9) < 8);
      fl = ($urandom_range(31) == 0);
      ca = (k > 0) && ($urandom_range(9) < 7);
      fv = ((q_free.size() - int'(ca)) < FNUM) && ($urandom_range(9) < 8);
      fp = 6'd0;
      if (fv && $urandom_range(15) != 0) begin
        idx = $urandom_range(owned.size() - 1);
        fp  = owned[idx];
        owned.delete(idx);
      end
      drive(av, fv, fp, ca, fl);
      fire = av && (q_free.size() > k) && !fl;
      if (ca) begin
        owned.push_back(q_free.pop_front());
        k--;
        commits++;
      end
      if (fire) k++;
      if (fl) k = 0;
      if (fv && fp != 6'd0) q_free.push_back(fp);
      tick();
    end
    drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    checks++;
    if (commits < 3 * FNUM) begin
      errors++; $display("FAIL rnd_wraps: got %0d commits want >= %0d", commits, 3 * FNUM);
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    test_reset();
    test_drain();
    test_empty_free();
    test_flush();
    test_flush_commit();
    test_free_zero();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
